varredor_matriz_param: RTL and testbench

Parametrised scan driver for an LED dot matrix of COLUNAS x LINHAS (default 5x7). It multiplexes one active column at a time and drives that column's row pattern. Each column has a programmable dwell time, followed by optional blanking cycles that suppress ghosting. New frames are double-buffered and are applied only at a frame boundary. It sits between the character/pattern generator and the matrix pins, and replaces the fixed 5x7 combinational decoder plus counter.

---
 rtl/varredor_matriz_param_pkg.sv | 24 ++
 rtl/varredor_matriz_param_if.sv | 42 ++++
 rtl/varredor_matriz_param_contador_coluna.sv | 108 ++++++++++
 rtl/varredor_matriz_param.sv | 111 +++++++++++
 tb/tb_varredor_matriz_param.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/varredor_matriz_param_pkg.sv
// Shared types, geometry defaults and width helpers for the LED matrix scan driver.
package varredor_pkg;

    typedef enum logic [1:0] {
        StOcioso = 2'd0,
        StExibe  = 2'd1,
        StApaga  = 2'd2
    } estado_e;

    localparam int unsigned ColunasPadrao = 5;
    localparam int unsigned LinhasPadrao  = 7;
    localparam int unsigned DwellPadrao   = 4;
    localparam int unsigned BlankPadrao   = 1;

    // Width of an index/counter covering 0..n-1, never less than one bit.
    function automatic int unsigned largura(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned maior(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/varredor_matriz_param_if.sv
// Pattern-generator side bundle of the matrix scan driver: frame load and pin drive.
interface varredor_matriz_param_if
    import varredor_pkg::*;
#(
    parameter int unsigned COLUNAS = ColunasPadrao,
    parameter int unsigned LINHAS  = LinhasPadrao
) ();

    localparam int unsigned ColW = largura(COLUNAS);

    logic                       habilita;
    logic [COLUNAS*LINHAS-1:0]  quadro;
    logic                       carregar;
    logic                       carregado;
    logic [COLUNAS-1:0]         colunas;
    logic [LINHAS-1:0]          linhas;
    logic [ColW-1:0]            coluna_atual;
    logic                       fim_quadro;

    modport master (
        output habilita,
        output quadro,
        output carregar,
        input  carregado,
        input  colunas,
        input  linhas,
        input  coluna_atual,
        input  fim_quadro
    );

    modport slave (
        input  habilita,
        input  quadro,
        input  carregar,
        output carregado,
        output colunas,
        output linhas,
        output coluna_atual,
        output fim_quadro
    );

endinterface

// File: rtl/varredor_matriz_param_contador_coluna.sv
// Scan sequencer: idle/lit/blank FSM, dwell/blank counter and column index with wrap.
module contador_coluna
    import varredor_pkg::*;
#(
    parameter int unsigned COLUNAS = ColunasPadrao,
    parameter int unsigned DWELL   = DwellPadrao,
    parameter int unsigned BLANK   = BlankPadrao,
    parameter int unsigned ColW    = largura(COLUNAS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            habilita,
    output estado_e         estado,
    output estado_e         estado_prox,
    output logic [ColW-1:0] coluna_atual,
    output logic [ColW-1:0] coluna_prox,
    output logic            avanca,
    output logic            fim_quadro
);

    localparam int unsigned CntW = largura(maior(DWELL, BLANK));
    localparam logic [CntW-1:0] DwellFim = CntW'(DWELL - 1);
    localparam logic [CntW-1:0] BlankFim = CntW'((BLANK == 0) ? 0 : BLANK - 1);
    localparam logic [ColW-1:0] ColFim   = ColW'(COLUNAS - 1);

    estado_e         estado_q, estado_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [ColW-1:0] col_q, col_d;
    logic [ColW-1:0] col_seguinte;
    logic            fim_q, fim_d;

    always_comb begin
        col_seguinte = (col_q == ColFim) ? '0 : col_q + 1'b1;
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        avanca       = 1'b0;

        case (estado_q)
            StOcioso: begin
                cnt_d = '0;
                col_d = '0;
                if (habilita) begin
                    estado_d = StExibe;
                end
            end
            StExibe: begin
                if (cnt_q == DwellFim) begin
                    cnt_d = '0;
                    if (BLANK == 0) begin
                        avanca = 1'b1;
                        col_d  = col_seguinte;
                    end else begin
                        estado_d = StApaga;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StApaga: begin
                if (cnt_q == BlankFim) begin
                    cnt_d    = '0;
                    avanca   = 1'b1;
                    col_d    = col_seguinte;
                    estado_d = StExibe;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = StOcioso;
                cnt_d    = '0;
                col_d    = '0;
            end
        endcase

        // Dropping the enable abandons the frame outright: no advance, no end-of-frame.
        if (!habilita) begin
            estado_d = StOcioso;
            cnt_d    = '0;
            col_d    = '0;
            avanca   = 1'b0;
        end

        fim_d = (estado_d == StExibe) && (col_d == ColFim) && (cnt_d == DwellFim);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= StOcioso;
            cnt_q    <= '0;
            col_q    <= '0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            fim_q    <= fim_d;
        end
    end

    assign estado       = estado_q;
    assign estado_prox  = estado_d;
    assign coluna_atual = col_q;
    assign coluna_prox  = col_d;
    assign fim_quadro   = fim_q;

endmodule

// File: rtl/varredor_matriz_param.sv
// LED dot-matrix scan driver: double-buffered frames, per-column dwell and blanking.
module varredor_matriz_param
    import varredor_pkg::*;
#(
    parameter int unsigned COLUNAS         = ColunasPadrao,
    parameter int unsigned LINHAS          = LinhasPadrao,
    parameter int unsigned DWELL           = DwellPadrao,
    parameter int unsigned BLANK           = BlankPadrao,
    parameter bit          COL_ATIVO_BAIXO = 1'b0,
    parameter bit          LIN_ATIVO_BAIXO = 1'b0
) (
    input  logic                   displayClock,
    input  logic                   reset,
    varredor_matriz_param_if.slave bus
);

    localparam int unsigned ColW = largura(COLUNAS);
    localparam int unsigned Bits = COLUNAS * LINHAS;
    localparam logic [ColW-1:0]    ColFim     = ColW'(COLUNAS - 1);
    localparam logic [COLUNAS-1:0] ColInativo = COL_ATIVO_BAIXO ? '1 : '0;
    localparam logic [LINHAS-1:0]  LinInativo = LIN_ATIVO_BAIXO ? '1 : '0;

    estado_e         estado, estado_prox;
    logic [ColW-1:0] coluna_atual, coluna_prox;
    logic            avanca, fim_quadro, fronteira;

    logic [Bits-1:0]    shadow_q, shadow_d;
    logic [Bits-1:0]    display_q, display_d;
    logic               pendente_q, pendente_d;
    logic               carregado_q, carregado_d;
    logic [COLUNAS-1:0] colunas_q, colunas_d;
    logic [LINHAS-1:0]  linhas_q, linhas_d;

    contador_coluna #(
        .COLUNAS (COLUNAS),
        .DWELL   (DWELL),
        .BLANK   (BLANK),
        .ColW    (ColW)
    ) u_contador (
        .clk          (displayClock),
        .reset        (reset),
        .habilita     (bus.habilita),
        .estado       (estado),
        .estado_prox  (estado_prox),
        .coluna_atual (coluna_atual),
        .coluna_prox  (coluna_prox),
        .avanca       (avanca),
        .fim_quadro   (fim_quadro)
    );

    always_comb begin
        // Scan start counts as a boundary so a frame loaded while idle shows immediately.
        fronteira = ((estado == StOcioso) && (estado_prox == StExibe))
                  || (avanca && (coluna_atual == ColFim));

        shadow_d    = shadow_q;
        display_d   = display_q;
        pendente_d  = pendente_q;
        carregado_d = 1'b0;

        if (bus.carregar) begin
            shadow_d   = bus.quadro;
            pendente_d = 1'b1;
        end

        if (fronteira) begin
            if (bus.carregar) begin
                display_d   = bus.quadro;
                pendente_d  = 1'b0;
                carregado_d = 1'b1;
            end else if (pendente_q) begin
                display_d   = shadow_q;
                pendente_d  = 1'b0;
                carregado_d = 1'b1;
            end
        end

        // Outputs are built from next-cycle state so the pins line up with coluna_atual.
        colunas_d = ColInativo;
        linhas_d  = LinInativo;
        if (estado_prox == StExibe) begin
            colunas_d = ColInativo ^ (COLUNAS'(1) << coluna_prox);
            linhas_d  = LinInativo ^ display_d[int'(coluna_prox) * LINHAS +: LINHAS];
        end
    end

    always_ff @(posedge displayClock) begin
        if (reset) begin
            shadow_q    <= '0;
            display_q   <= '0;
            pendente_q  <= 1'b0;
            carregado_q <= 1'b0;
            colunas_q   <= ColInativo;
            linhas_q    <= LinInativo;
        end else begin
            shadow_q    <= shadow_d;
            display_q   <= display_d;
            pendente_q  <= pendente_d;
            carregado_q <= carregado_d;
            colunas_q   <= colunas_d;
            linhas_q    <= linhas_d;
        end
    end

    assign bus.carregado    = carregado_q;
    assign bus.colunas      = colunas_q;
    assign bus.linhas       = linhas_q;
    assign bus.coluna_atual = coluna_atual;
    assign bus.fim_quadro   = fim_quadro;

endmodule

// File: tb/tb_varredor_matriz_param.sv
// Directed bench: default 5x7 scan plus an 8x8 inverted-polarity, no-blank instance.
module tb_varredor_matriz_param;

    logic clk = 1'b0;
    logic reset;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    varredor_matriz_param_if #(.COLUNAS(5), .LINHAS(7)) bus_a ();
    varredor_matriz_param_if #(.COLUNAS(8), .LINHAS(8)) bus_b ();

    varredor_matriz_param #(
        .COLUNAS(5), .LINHAS(7), .DWELL(4), .BLANK(1),
        .COL_ATIVO_BAIXO(1'b0), .LIN_ATIVO_BAIXO(1'b0)
    ) dut_a (
        .displayClock (clk),
        .reset        (reset),
        .bus          (bus_a)
    );

    varredor_matriz_param #(
        .COLUNAS(8), .LINHAS(8), .DWELL(1), .BLANK(0),
        .COL_ATIVO_BAIXO(1'b1), .LIN_ATIVO_BAIXO(1'b1)
    ) dut_b (
        .displayClock (clk),
        .reset        (reset),
        .bus          (bus_b)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Idle for one cycle, then enable: returns at scan position 0 (column 0 lit).
    task automatic restart_a();
        bus_a.habilita = 1'b0;
        step(1);
        bus_a.habilita = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_a.habilita = 1'b0; bus_a.carregar = 1'b0; bus_a.quadro = '0;
        bus_b.habilita = 1'b0; bus_b.carregar = 1'b0; bus_b.quadro = '0;
        step(2);
        bus_a.habilita = 1'b1; // reset must dominate enable
        step(2);
        vecs++; if (bus_a.colunas !== 5'b00000) begin errs++;
            $display("FAIL reset_colunas got %b want %b", bus_a.colunas, 5'b00000); end
        vecs++; if (bus_a.linhas !== 7'h00) begin errs++;
            $display("FAIL reset_linhas got %h want %h", bus_a.linhas, 7'h00); end
        vecs++; if (bus_a.coluna_atual !== 3'd0) begin errs++;
            $display("FAIL reset_coluna got %0d want 0", bus_a.coluna_atual); end
        vecs++; if (bus_a.carregado !== 1'b0 || bus_a.fim_quadro !== 1'b0) begin errs++;
            $display("FAIL reset_pulsos got %b%b want 00", bus_a.carregado, bus_a.fim_quadro); end
        vecs++; if (bus_b.colunas !== 8'hFF) begin errs++;
            $display("FAIL reset_colunas_inv got %h want ff", bus_b.colunas); end
        vecs++; if (bus_b.linhas !== 8'hFF) begin errs++;
            $display("FAIL reset_linhas_inv got %h want ff", bus_b.linhas); end
        bus_a.habilita = 1'b0;
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_scan();
        bus_a.quadro = '1; bus_a.carregar = 1'b1;
        step(1);
        bus_a.carregar = 1'b0; bus_a.habilita = 1'b1;
        step(1);
        for (int i = 0; i < 30; i++) begin
            int k, c, ph;
            logic [4:0] ec;
            logic [6:0] el;
            k = i % 25; c = k / 5; ph = k % 5;
            ec = (ph < 4) ? (5'b00001 << c) : 5'b00000;
            el = (ph < 4) ? 7'h7F : 7'h00;
            vecs++; if (bus_a.colunas !== ec) begin errs++;
                $display("FAIL scan_colunas@%0d got %b want %b", i, bus_a.colunas, ec); end
            vecs++; if (bus_a.linhas !== el) begin errs++;
                $display("FAIL scan_linhas@%0d got %h want %h", i, bus_a.linhas, el); end
            vecs++; if (bus_a.coluna_atual !== 3'(c)) begin errs++;
                $display("FAIL scan_coluna@%0d got %0d want %0d", i, bus_a.coluna_atual, c); end
            vecs++; if (bus_a.fim_quadro !== (k == 23)) begin errs++;
                $display("FAIL scan_fim@%0d got %b want %b", i, bus_a.fim_quadro, k == 23); end
            vecs++; if (bus_a.carregado !== (i == 0)) begin errs++;
                $display("FAIL scan_carregado@%0d got %b want %b", i, bus_a.carregado, i == 0); end
            step(1);
        end
    endtask

    task automatic test_load_midframe();
        restart_a();
        step(10);
        bus_a.quadro = 35'h2_AAAA_AAAA; bus_a.carregar = 1'b1;
        step(1);
        bus_a.carregar = 1'b0;
        for (int p = 11; p < 25; p++) begin
            logic [6:0] el;
            el = ((p % 5) < 4) ? 7'h7F : 7'h00;
            vecs++; if (bus_a.linhas !== el || bus_a.carregado !== 1'b0) begin errs++;
                $display("FAIL mid_sem_tearing@%0d got %h/%b want %h/0", p, bus_a.linhas,
                         bus_a.carregado, el); end
            step(1);
        end
        vecs++; if (bus_a.carregado !== 1'b1) begin errs++;
            $display("FAIL mid_carregado got %b want 1", bus_a.carregado); end
        vecs++; if (bus_a.colunas !== 5'b00001 || bus_a.linhas !== 7'h2A) begin errs++;
            $display("FAIL mid_col0 got %b/%h want 00001/2a", bus_a.colunas, bus_a.linhas); end
        step(1);
        vecs++; if (bus_a.carregado !== 1'b0) begin errs++;
            $display("FAIL mid_pulso_unico got %b want 0", bus_a.carregado); end
        step(4);
        vecs++; if (bus_a.colunas !== 5'b00010 || bus_a.linhas !== 7'h55) begin errs++;
            $display("FAIL mid_col1 got %b/%h want 00010/55", bus_a.colunas, bus_a.linhas); end
    endtask

    task automatic test_double_load();
        int pulsos;
        pulsos = 0;
        restart_a();
        step(3);
        bus_a.quadro = '1; bus_a.carregar = 1'b1;
        step(1);
        bus_a.carregar = 1'b0;
        step(4);
        bus_a.quadro = 35'h0_0000_0003; bus_a.carregar = 1'b1;
        step(1);
        bus_a.carregar = 1'b0;
        for (int p = 9; p < 50; p++) begin
            if (bus_a.carregado === 1'b1) pulsos++;
            if (p == 25) begin
                vecs++; if (bus_a.linhas !== 7'h03 || bus_a.carregado !== 1'b1) begin errs++;
                    $display("FAIL duplo_col0 got %h/%b want 03/1", bus_a.linhas,
                             bus_a.carregado); end
            end
            if (p == 30) begin
                vecs++; if (bus_a.linhas !== 7'h00) begin errs++;
                    $display("FAIL duplo_col1 got %h want 00", bus_a.linhas); end
            end
            step(1);
        end
        vecs++; if (pulsos != 1) begin errs++;
            $display("FAIL duplo_pulsos got %0d want 1", pulsos); end
    endtask

    task automatic test_boundary_load();
        restart_a();
        step(24);
        bus_a.quadro = 35'h0_0000_0055; bus_a.carregar = 1'b1;
        step(1);
        bus_a.carregar = 1'b0;
        vecs++; if (bus_a.carregado !== 1'b1) begin errs++;
            $display("FAIL borda_carregado got %b want 1", bus_a.carregado); end
        vecs++; if (bus_a.colunas !== 5'b00001 || bus_a.linhas !== 7'h55) begin errs++;
            $display("FAIL borda_col0 got %b/%h want 00001/55", bus_a.colunas, bus_a.linhas); end
        step(25);
        vecs++; if (bus_a.carregado !== 1'b0 || bus_a.linhas !== 7'h55) begin errs++;
            $display("FAIL borda_sem_pendente got %b/%h want 0/55", bus_a.carregado,
                     bus_a.linhas); end
    endtask

    task automatic test_habilita_drop();
        restart_a();
        step(15);
        vecs++; if (bus_a.coluna_atual !== 3'd3) begin errs++;
            $display("FAIL queda_pre got %0d want 3", bus_a.coluna_atual); end
        bus_a.habilita = 1'b0;
        step(1);
        vecs++; if (bus_a.colunas !== 5'b00000 || bus_a.linhas !== 7'h00) begin errs++;
            $display("FAIL queda_saidas got %b/%h want 00000/00", bus_a.colunas,
                     bus_a.linhas); end
        vecs++; if (bus_a.coluna_atual !== 3'd0 || bus_a.fim_quadro !== 1'b0) begin errs++;
            $display("FAIL queda_coluna got %0d/%b want 0/0", bus_a.coluna_atual,
                     bus_a.fim_quadro); end
        step(3);
        vecs++; if (bus_a.colunas !== 5'b00000) begin errs++;
            $display("FAIL queda_ocioso got %b want 00000", bus_a.colunas); end
        bus_a.habilita = 1'b1;
        step(1);
        vecs++; if (bus_a.colunas !== 5'b00001 || bus_a.linhas !== 7'h55) begin errs++;
            $display("FAIL retorno_col0 got %b/%h want 00001/55", bus_a.colunas,
                     bus_a.linhas); end
        vecs++; if (bus_a.carregado !== 1'b0 || bus_a.coluna_atual !== 3'd0) begin errs++;
            $display("FAIL retorno_estado got %b/%0d want 0/0", bus_a.carregado,
                     bus_a.coluna_atual); end
        step(4);
        vecs++; if (bus_a.colunas !== 5'b00000) begin errs++;
            $display("FAIL retorno_apaga got %b want 00000", bus_a.colunas); end
        step(1);
        vecs++; if (bus_a.colunas !== 5'b00010) begin errs++;
            $display("FAIL retorno_col1 got %b want 00010", bus_a.colunas); end
    endtask

    task automatic test_sweep();
        bus_b.quadro = 64'h0102_0408_1020_4080; bus_b.carregar = 1'b1;
        step(1);
        bus_b.carregar = 1'b0; bus_b.habilita = 1'b1;
        step(1);
        for (int i = 0; i < 16; i++) begin
            int c;
            logic [7:0] ec, el, um, topo;
            c = i % 8;
            um = 8'h01; topo = 8'h80;
            ec = ~(um << c);
            el = ~(topo >> c);
            vecs++; if (bus_b.colunas !== ec) begin errs++;
                $display("FAIL sweep_colunas@%0d got %b want %b", i, bus_b.colunas, ec); end
            vecs++; if (bus_b.linhas !== el) begin errs++;
                $display("FAIL sweep_linhas@%0d got %h want %h", i, bus_b.linhas, el); end
            vecs++; if (bus_b.coluna_atual !== 3'(c)) begin errs++;
                $display("FAIL sweep_coluna@%0d got %0d want %0d", i, bus_b.coluna_atual, c); end
            vecs++; if (bus_b.fim_quadro !== (c == 7)) begin errs++;
                $display("FAIL sweep_fim@%0d got %b want %b", i, bus_b.fim_quadro, c == 7); end
            vecs++; if (bus_b.carregado !== (i == 0)) begin errs++;
                $display("FAIL sweep_carregado@%0d got %b want %b", i, bus_b.carregado, i == 0);
            end
            step(1);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_double_load();
        test_boundary_load();
        test_habilita_drop();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
